// File: rtl/prt_dp_pm_mem_ldr.sv
// ---------------------------------------------------------------------------
// prt_dp_pm_mem_ldr
// Sequences the PM exchange memory-update stream into addressed write cycles
// for the policy maker ROM (instructions) and RAM (data). The PM is held in
// reset while a load session runs; progress, word counts and errors are
// reported to the host.
//
// Optional feature macro: PRT_DP_PM_MEM_LDR_CHK_EN
//   defined   : CHK_OUT = running mod-2^32 sum of every word written
//   undefined : CHK_OUT tied to 0, no adder
//
// Ports
//   RST_IN        async active-high reset
//   CLK_IN        clock, rising edge
//   MEM_STR_IN    session start/stop pulse
//   MEM_DAT_IN    incoming memory word
//   MEM_VLD_IN    word valid: bit0 ROM, bit1 RAM
//   PM_RUN_IN     host run request (releases PM reset after a good load)
//   ROM_WR_OUT    ROM write strobe
//   ROM_ADR_OUT   ROM write address
//   RAM_WR_OUT    RAM write strobe
//   RAM_ADR_OUT   RAM write address
//   MEM_DAT_OUT   write data shared by ROM and RAM
//   PM_RST_OUT    PM reset, active-high
//   BUSY_OUT      session active
//   DONE_OUT      last session completed cleanly (sticky)
//   ERR_OUT       last session failed (sticky)
//   ROM_WRDS_OUT  ROM words written this session
//   RAM_WRDS_OUT  RAM words written this session
//   CHK_OUT       checksum of written words (see macro above)
// ---------------------------------------------------------------------------
module prt_dp_pm_mem_ldr #(
    parameter int unsigned P_ROM_ADR = 14,
    parameter int unsigned P_RAM_ADR = 12
) (
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    input  logic                 MEM_STR_IN,
    input  logic [31:0]          MEM_DAT_IN,
    input  logic [1:0]           MEM_VLD_IN,
    input  logic                 PM_RUN_IN,
    output logic                 ROM_WR_OUT,
    output logic [P_ROM_ADR-1:0] ROM_ADR_OUT,
    output logic                 RAM_WR_OUT,
    output logic [P_RAM_ADR-1:0] RAM_ADR_OUT,
    output logic [31:0]          MEM_DAT_OUT,
    output logic                 PM_RST_OUT,
    output logic                 BUSY_OUT,
    output logic                 DONE_OUT,
    output logic                 ERR_OUT,
    output logic [P_ROM_ADR:0]   ROM_WRDS_OUT,
    output logic [P_RAM_ADR:0]   RAM_WRDS_OUT,
    output logic [31:0]          CHK_OUT
);

    localparam int unsigned ROM_CNT_W = P_ROM_ADR + 1;
    localparam int unsigned RAM_CNT_W = P_RAM_ADR + 1;

    // Count value equal to memory depth: one more word would overflow
    localparam logic [ROM_CNT_W-1:0] ROM_FULL = {1'b1, {P_ROM_ADR{1'b0}}};
    localparam logic [RAM_CNT_W-1:0] RAM_FULL = {1'b1, {P_RAM_ADR{1'b0}}};
    localparam logic [ROM_CNT_W-1:0] ROM_ONE  = ROM_CNT_W'(1);
    localparam logic [RAM_CNT_W-1:0] RAM_ONE  = RAM_CNT_W'(1);

    localparam logic [1:0] VLD_ROM  = 2'b01;
    localparam logic [1:0] VLD_RAM  = 2'b10;
    localparam logic [1:0] VLD_BOTH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                 rom_wr,  rom_wr_nxt;
    logic [P_ROM_ADR-1:0] rom_adr, rom_adr_nxt;
    logic                 ram_wr,  ram_wr_nxt;
    logic [P_RAM_ADR-1:0] ram_adr, ram_adr_nxt;
    logic [31:0]          dat,     dat_nxt;
    logic                 pm_rst,  pm_rst_nxt;
    logic                 busy,    busy_nxt;
    logic                 done,    done_nxt;
    logic                 err,     err_nxt;
    logic [ROM_CNT_W-1:0] rom_cnt, rom_cnt_nxt;
    logic [RAM_CNT_W-1:0] ram_cnt, ram_cnt_nxt;

`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
    logic [31:0]          chk,     chk_nxt;
`endif

    // Request decode and overflow detection for the current word
    logic rom_req_c;
    logic ram_req_c;
    logic reject_c;

    assign rom_req_c = (MEM_VLD_IN == VLD_ROM);
    assign ram_req_c = (MEM_VLD_IN == VLD_RAM);
    assign reject_c  = (MEM_VLD_IN == VLD_BOTH)
                     || (rom_req_c && (rom_cnt == ROM_FULL))
                     || (ram_req_c && (ram_cnt == RAM_FULL));

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        rom_wr_nxt  = 1'b0;
        ram_wr_nxt  = 1'b0;
        rom_adr_nxt = rom_adr;
        ram_adr_nxt = ram_adr;
        dat_nxt     = dat;
        pm_rst_nxt  = 1'b1;
        busy_nxt    = busy;
        done_nxt    = done;
        err_nxt     = err;
        rom_cnt_nxt = rom_cnt;
        ram_cnt_nxt = ram_cnt;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
        chk_nxt     = chk;
`endif

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // Start of a new session wipes all session state
                if (MEM_STR_IN) begin
                    state_nxt   = ST_LOAD;
                    rom_cnt_nxt = '0;
                    ram_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    err_nxt     = 1'b0;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
                    chk_nxt     = '0;
`endif
                end
            end

            ST_LOAD: begin
                if (reject_c) begin
                    // Offending word is dropped; counts freeze at last good value
                    state_nxt = ST_ERR;
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    if (rom_req_c) begin
                        rom_wr_nxt  = 1'b1;
                        rom_adr_nxt = rom_cnt[P_ROM_ADR-1:0];
                        dat_nxt     = MEM_DAT_IN;
                        rom_cnt_nxt = rom_cnt + ROM_ONE;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
                        chk_nxt     = chk + MEM_DAT_IN;
`endif
                    end
                    if (ram_req_c) begin
                        ram_wr_nxt  = 1'b1;
                        ram_adr_nxt = ram_cnt[P_RAM_ADR-1:0];
                        dat_nxt     = MEM_DAT_IN;
                        ram_cnt_nxt = ram_cnt + RAM_ONE;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
                        chk_nxt     = chk + MEM_DAT_IN;
`endif
                    end
                    // A word arriving with the stop pulse is still written
                    if (MEM_STR_IN) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                // One cycle for the final strobe; stop/start pulses ignored here
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // PM leaves reset only after a clean load and on host request
        if (state_nxt == ST_DONE) begin
            pm_rst_nxt = ~PM_RUN_IN;
        end
    end

    // State and output registers
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state   <= ST_IDLE;
            rom_wr  <= 1'b0;
            ram_wr  <= 1'b0;
            rom_adr <= '0;
            ram_adr <= '0;
            dat     <= '0;
            pm_rst  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rom_cnt <= '0;
            ram_cnt <= '0;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
            chk     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            rom_wr  <= rom_wr_nxt;
            ram_wr  <= ram_wr_nxt;
            rom_adr <= rom_adr_nxt;
            ram_adr <= ram_adr_nxt;
            dat     <= dat_nxt;
            pm_rst  <= pm_rst_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            rom_cnt <= rom_cnt_nxt;
            ram_cnt <= ram_cnt_nxt;
`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
            chk     <= chk_nxt;
`endif
        end
    end

    assign ROM_WR_OUT   = rom_wr;
    assign ROM_ADR_OUT  = rom_adr;
    assign RAM_WR_OUT   = ram_wr;
    assign RAM_ADR_OUT  = ram_adr;
    assign MEM_DAT_OUT  = dat;
    assign PM_RST_OUT   = pm_rst;
    assign BUSY_OUT     = busy;
    assign DONE_OUT     = done;
    assign ERR_OUT      = err;
    assign ROM_WRDS_OUT = rom_cnt;
    assign RAM_WRDS_OUT = ram_cnt;

`ifdef PRT_DP_PM_MEM_LDR_CHK_EN
    assign CHK_OUT = chk;
`else
    assign CHK_OUT = 32'd0;
`endif

endmodule
